systolic_seq: RTL and testbench

Sequencing controller for the N×N systolic array of PE cells. It accepts a matrix-multiply job of depth `k_len` and pulses the accumulator clear. It then drives the array enable and per-lane skewed operand-valid/index signals to the A-row and B-column feeders. Once the wavefront has propagated it flushes, drains the result rows one per handshake, and signals completion. It sits between the host command interface and the operand buffers/array.

---
 rtl/systolic_pkg.sv | 29 ++
 rtl/systolic_seq_skew_gen.sv | 32 +++
 rtl/systolic_seq.sv | 132 +++++++++++++
 tb/tb_systolic_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg -- shared states and width helpers for the systolic array slice (rev 1.0)
`default_nettype none

package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic int kw_of(input int k_max);
    return $clog2(k_max + 1);
  endfunction

  function automatic int kiw_of(input int k_max);
    return (k_max <= 1) ? 1 : $clog2(k_max);
  endfunction

  function automatic int rw_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_seq_skew_gen.sv
// skew_gen -- maps the FEED step counter onto per-lane skewed operand valid/index (rev 1.0)
`default_nettype none

module skew_gen
  import systolic_pkg::*;
#(
  parameter int N   = 4,
  parameter int KW  = 5,
  parameter int KIW = 4,
  parameter int TW  = 8
) (
  input  logic [TW-1:0]    t,
  input  logic [KW-1:0]    k_len,
  input  logic             feed,
  output logic [N-1:0]     lane_vld,
  output logic [N*KIW-1:0] lane_k
);

  logic [TW-1:0] k_ext;
  assign k_ext = {{(TW-KW){1'b0}}, k_len};

  // Lane i lags lane 0 by i steps; the difference is formed at full width so it never wraps.
  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam logic [TW-1:0] IDX = TW'(i);

    assign lane_vld[i]             = feed && (t >= IDX) && ((t - IDX) < k_ext);
    assign lane_k[i*KIW +: KIW]    = lane_vld[i] ? KIW'(t - IDX) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/systolic_seq.sv
// systolic_seq -- job sequencer for the NxN systolic array (rev 1.0)
// Clears accumulators, feeds skewed operands, flushes, then drains result rows.
`default_nettype none

module systolic_seq
  import systolic_pkg::*;
#(
  parameter int N     = 4,
  parameter int K_MAX = 16,
  parameter int KW    = kw_of(K_MAX),
  parameter int KIW   = kiw_of(K_MAX),
  parameter int RW    = rw_of(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KW-1:0]    k_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             arr_clr,
  output logic             arr_en,
  output logic [N-1:0]     lane_vld,
  output logic [N*KIW-1:0] lane_k,
  output logic             drain_vld,
  output logic [RW-1:0]    drain_row,
  input  logic             drain_rdy
);

  localparam int TW = KW + RW + 1;

  state_t        state_q, state_d;
  logic [TW-1:0] t_q;
  logic [KW-1:0] k_q;
  logic [RW-1:0] row_q;
  logic          err_q;

  logic          k_ok;
  logic [TW-1:0] t_last;
  logic [RW-1:0] row_last;

  assign k_ok     = (k_len != '0) && (k_len <= KW'(K_MAX));
  // Last feed step is k_len+2N-3: the wavefront needs 2N-2 extra steps to reach PE(N-1,N-1).
  assign t_last   = {{(TW-KW){1'b0}}, k_q} + TW'(2*N) - TW'(3);
  assign row_last = RW'(N-1);

  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    done      = 1'b0;
    arr_clr   = 1'b0;
    arr_en    = 1'b0;
    drain_vld = 1'b0;
    drain_row = '0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start && k_ok) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        arr_clr = 1'b1;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        arr_en = 1'b1;
        if (t_q == t_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_vld = 1'b1;
        drain_row = row_q;
        if (drain_rdy && (row_q == row_last)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      k_q     <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == ST_IDLE) && start && !k_ok;
      case (state_q)
        ST_IDLE: begin
          if (start && k_ok) begin
            k_q <= k_len;
            t_q <= '0;
          end
        end
        ST_FEED:  t_q   <= t_q + TW'(1);
        ST_FLUSH: row_q <= '0;
        ST_DRAIN: begin
          // Row holds at N-1 after its acceptance so it never wraps visibly.
          if (drain_rdy && (row_q != row_last)) row_q <= row_q + RW'(1);
        end
        default: ;
      endcase
    end
  end

  assign err = err_q;

  skew_gen #(
    .N   (N),
    .KW  (KW),
    .KIW (KIW),
    .TW  (TW)
  ) u_skew (
    .t        (t_q),
    .k_len    (k_q),
    .feed     (arr_en),
    .lane_vld (lane_vld),
    .lane_k   (lane_k)
  );

endmodule

`default_nettype wire

// File: tb/tb_systolic_seq.sv
// tb_systolic_seq -- scoreboard bench for systolic_seq with N=4, K_MAX=16 (rev 1.0)
`default_nettype none

module tb_systolic_seq;

  localparam int N   = 4;
  localparam int KW  = 5;
  localparam int KIW = 4;
  localparam int RW  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [KW-1:0]    k_len;
  logic             busy, done, err, arr_clr, arr_en, drain_vld, drain_rdy;
  logic [N-1:0]     lane_vld;
  logic [N*KIW-1:0] lane_k;
  logic [RW-1:0]    drain_row;

  systolic_seq #(.N(N), .K_MAX(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .arr_clr   (arr_clr),
    .arr_en    (arr_en),
    .lane_vld  (lane_vld),
    .lane_k    (lane_k),
    .drain_vld (drain_vld),
    .drain_row (drain_row),
    .drain_rdy (drain_rdy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic        clr;
    logic        en;
    logic [3:0]  vld;
    logic [15:0] lk;
    logic        dvld;
    logic [1:0]  drow;
  } obs_t;

  typedef struct {
    int k;
    int stall;
    bit poke;
    int done_c;
    int en_n;
  } job_t;

  typedef struct {
    int          t;
    logic [3:0]  vld;
    logic [15:0] lk;
  } lane_t;

  job_t  jt[5];
  lane_t lt[6];
  obs_t  sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic obs_t sample();
    return {busy, done, err, arr_clr, arr_en, lane_vld, lane_k, drain_vld, drain_row};
  endfunction

  // Expected outputs at cycle c of a job, from the documented cycle timeline.
  function automatic obs_t model(input int c, input int k, input int stall);
    obs_t e;
    int fl = k + 2*N;
    int dl = fl + 1;
    int dc = k + 3*N + 1 + stall;
    int t  = c - 2;
    int d, r;
    e      = '0;
    e.busy = (c >= 1) && (c <= dc);
    e.done = (c == dc);
    e.clr  = (c == 1);
    e.en   = (c >= 2) && (c < fl);
    if (e.en) begin
      for (int i = 0; i < N; i++) begin
        if (t >= i && (t - i) < k) begin
          e.vld[i]          = 1'b1;
          e.lk[i*KIW +: KIW] = 4'(t - i);
        end
      end
    end
    if (c >= dl && c < dc) begin
      d      = c - dl;
      r      = (d <= 1) ? d : ((d <= 1 + stall) ? 1 : d - stall);
      e.dvld = 1'b1;
      e.drow = 2'(r);
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input job_t j, input bit lanes);
    int dl = j.k + 2*N + 1;
    int dc = j.k + 3*N + 1 + j.stall;
    int done_seen = -1;
    int en_n = 0;
    obs_t a, e;
    for (int c = 0; c <= dc; c++) sb.push_back(model(c, j.k, j.stall));
    for (int c = 0; c <= dc; c++) begin
      start     = (c == 0) || (j.poke && (c == 4 || c == dl + 1));
      k_len     = (c == 0) ? KW'(j.k) : (j.poke ? '0 : KW'(j.k));
      drain_rdy = !(c >= dl + 1 && c <= dl + j.stall);
      a = sample();
      e = sb.pop_front();
      check($sformatf("job k%0d s%0d p%0d c%0d", j.k, j.stall, j.poke, c), 32'(a), 32'(e));
      if (a.done && done_seen < 0) done_seen = c;
      if (a.en) en_n++;
      for (int m = 0; m < 6; m++) begin
        if (lanes && c == lt[m].t + 2) begin
          check($sformatf("lane_vld t%0d", lt[m].t), 32'(a.vld), 32'(lt[m].vld));
          check($sformatf("lane_k t%0d", lt[m].t), 32'(a.lk), 32'(lt[m].lk));
        end
      end
      tick();
    end
    start     = 1'b0;
    drain_rdy = 1'b1;
    check($sformatf("done cycle k%0d", j.k), 32'(done_seen), 32'(j.done_c));
    check($sformatf("arr_en cycles k%0d", j.k), 32'(en_n), 32'(j.en_n));
  endtask

  task automatic run_err(input int k);
    obs_t e1;
    e1     = '0;
    e1.err = 1'b1;
    sb.push_back('0);
    sb.push_back(e1);
    sb.push_back('0);
    start = 1'b1;
    k_len = KW'(k);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("illegal k%0d c%0d", k, c), 32'(sample()), 32'(sb.pop_front()));
      tick();
      start = 1'b0;
    end
  endtask

  task automatic run_abort();
    for (int c = 0; c <= 6; c++) sb.push_back(model(c, 3, 0));
    k_len = 5'd3;
    for (int c = 0; c <= 6; c++) begin
      start = (c == 0);
      check($sformatf("abort job c%0d", c), 32'(sample()), 32'(sb.pop_front()));
      if (c < 6) tick();
    end
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("abort async outputs", 32'(sample()), 32'h0);
    #2 rst_n = 1'b1;
    tick();
    check("abort idle after release", 32'(sample()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    jt[0] = '{3, 0, 1'b0, 16, 9};
    jt[1] = '{3, 2, 1'b0, 18, 9};
    jt[2] = '{3, 0, 1'b1, 16, 9};
    jt[3] = '{16, 0, 1'b0, 29, 22};
    jt[4] = '{1, 0, 1'b0, 14, 7};
    lt[0] = '{0, 4'b0001, 16'h0000};
    lt[1] = '{1, 4'b0011, 16'h0001};
    lt[2] = '{3, 4'b1110, 16'h0120};
    lt[3] = '{5, 4'b1000, 16'h2000};
    lt[4] = '{6, 4'b0000, 16'h0000};
    lt[5] = '{8, 4'b0000, 16'h0000};

    rst_n     = 1'b0;
    start     = 1'b1;
    k_len     = 5'd3;
    drain_rdy = 1'b1;
    #1 check("reset outputs", 32'(sample()), 32'h0);
    tick();
    tick();
    check("reset held with start", 32'(sample()), 32'h0);
    start = 1'b0;
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("idle after reset c%0d", c), 32'(sample()), 32'h0);
    end

    run_job(jt[0], 1'b1);
    run_job(jt[1], 1'b0);
    run_job(jt[2], 1'b0);
    run_job(jt[3], 1'b0);
    run_err(0);
    run_err(17);
    run_abort();
    run_job(jt[4], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
